bsh_pipe: RTL

- Parametrised, pipelined successor to the 32-bit combinational log-shifter. One shift stage per shift-amount bit, each stage registered.
- Adds arithmetic and rotate modes, valid/ready flow control with backpressure, and a pass-through tag.
- Sits between operand-issue logic and writeback in the datapath. Sustains 1 op/cycle when not stalled.

---
 rtl/bsh_pkg.sv | 8 +
 rtl/bsh_pipe_stage.sv | 43 ++++
 rtl/bsh_pipe.sv | 52 +++++
 3 files changed

// File: rtl/bsh_pkg.sv
// bsh_pkg: shared mode and direction encodings for the pipelined barrel shifter
package bsh_pkg;
    localparam logic [1:0] BSH_LOGIC = 2'b00;
    localparam logic [1:0] BSH_ARITH = 2'b01;
    localparam logic [1:0] BSH_ROT   = 2'b10;
    localparam logic       BSH_LEFT  = 1'b0;
    localparam logic       BSH_RIGHT = 1'b1;
endpackage

// File: rtl/bsh_pipe_stage.sv
// bsh_pipe_stage: conditional shift by SHIFT bits followed by a stall-holding register
module bsh_pipe_stage import bsh_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int SHIFT = 1,
    parameter int SIDEW = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic             in_valid,
    input  logic             in_en,
    input  logic             in_dir,
    input  logic             in_fill,
    input  logic [1:0]       in_mode,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SIDEW-1:0] in_side,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [SIDEW-1:0] out_side
);
    logic rot, arith;
    logic [WIDTH-1:0] left, right, shifted;
    // Reserved mode 11 matches neither decode and so falls through to logical.
    always_comb begin
        rot     = in_mode == BSH_ROT;
        arith   = in_mode == BSH_ARITH;
        left    = (in_data << SHIFT) | (rot ? in_data >> (WIDTH - SHIFT) : '0);
        right   = (in_data >> SHIFT) | (rot ? in_data << (WIDTH - SHIFT)
                                      : arith ? {WIDTH{in_fill}} << (WIDTH - SHIFT) : '0);
        shifted = !in_en ? in_data : in_dir == BSH_RIGHT ? right : left;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_side  <= '0;
        end else if (adv) begin
            out_valid <= in_valid;
            out_data  <= shifted;
            out_side  <= in_side;
        end
    end
endmodule

// File: rtl/bsh_pipe.sv
// bsh_pipe: pipelined log-shifter, one registered stage per shift-amount bit
module bsh_pipe import bsh_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH),
    parameter int TAGW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_sh,
    input  logic             in_dir,
    input  logic [1:0]       in_mode,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAGW-1:0]  out_tag
);
    // Side payload {fill, dir, mode, sh, tag}; fill is the operand's sign captured at issue.
    localparam int SW = TAGW + SHW + 4;
    logic             advance;
    logic             v    [SHW+1];
    logic [WIDTH-1:0] d    [SHW+1];
    logic [SW-1:0]    side [SHW+1];
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign v[0]      = in_valid;
    assign d[0]      = in_data;
    assign side[0]   = {in_data[WIDTH-1], in_dir, in_mode, in_sh, in_tag};
    assign out_valid = v[SHW];
    assign out_data  = d[SHW];
    assign out_tag   = side[SHW][TAGW-1:0];
    for (genvar k = 0; k < SHW; k++) begin : g_stage
        bsh_pipe_stage #(.WIDTH(WIDTH), .SHIFT(1 << k), .SIDEW(SW)) u_stage (
            .clk      (clk),
            .rst      (rst),
            .adv      (advance),
            .in_valid (v[k]),
            .in_en    (side[k][TAGW+k]),
            .in_dir   (side[k][SW-2]),
            .in_fill  (side[k][SW-1]),
            .in_mode  (side[k][SW-3 -: 2]),
            .in_data  (d[k]),
            .in_side  (side[k]),
            .out_valid(v[k+1]),
            .out_data (d[k+1]),
            .out_side (side[k+1])
        );
    end
endmodule
